pipe_addsub: RTL and testbench

- Parametrised, pipelined two's-complement add/subtract unit with full NZCV flag generation. It is the next-generation replacement for the fixed 64-bit combinational subtractor in the ALU.
- The carry chain is split into STAGES equal chunks, one chunk per clock, so wide operands meet timing.
- Uses a valid/ready handshake so the execute stage can stall it.

---
 rtl/pipe_addsub.sv | 168 ++++++++++++++++
 tb/tb_pipe_addsub.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/subtract with NZCV flags; the carry chain is cut into STAGES chunks, one per clock.
// Define PIPE_ADDSUB_SAT_EN to enable signed saturation selected by op[1].
module pipe_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_flag,
    output logic             v_flag,
    output logic             n_flag,
    output logic             z_flag
);
    localparam int CW = (STAGES > 0) ? (WIDTH / STAGES) : 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
            $error("pipe_addsub: WIDTH must be a positive multiple of STAGES");
        end
    endgenerate

    logic             adv;
    logic             sat_sel;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             c_reg;
    logic             v_reg;
    logic             n_reg;
    logic             z_reg;

    logic             fin_valid;
    logic [WIDTH-1:0] fin_result;
    logic             fin_c;
    logic             fin_v;
    logic             fin_z;

    // One shared advance: every register moves together, so bubbles never overtake a stalled head.
    assign adv      = ~out_valid_reg | out_ready;
    assign in_ready = adv;

`ifdef PIPE_ADDSUB_SAT_EN
    assign sat_sel = op[1];
`else
    logic sat_unused;
    assign sat_unused = op[1];
    assign sat_sel    = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int REM_W  = (STAGES - gi) * CW;
            localparam int DONE_W = (gi + 1) * CW;

            logic              valid_in;
            logic [REM_W-1:0]  rem_a;
            logic [REM_W-1:0]  rem_bp;
            logic              carry_in;
            logic              zero_in;
            logic              sat_in;
            logic [CW:0]       chunk_sum;
            logic [DONE_W-1:0] sum_next;
            logic              zero_next;

            // Operands shrink by one chunk per stage while finished sum chunks accumulate below.
            if (gi == 0) begin : g_head
                assign valid_in = in_valid;
                assign rem_a    = a;
                assign rem_bp   = op[0] ? ~b : b;
                assign carry_in = op[0];
                assign zero_in  = 1'b1;
                assign sat_in   = sat_sel;
                assign sum_next = chunk_sum[CW-1:0];
            end else begin : g_body
                assign valid_in = g_stage[gi-1].g_reg.valid_reg;
                assign rem_a    = g_stage[gi-1].g_reg.a_reg;
                assign rem_bp   = g_stage[gi-1].g_reg.bp_reg;
                assign carry_in = g_stage[gi-1].g_reg.carry_reg;
                assign zero_in  = g_stage[gi-1].g_reg.zero_reg;
                assign sat_in   = g_stage[gi-1].g_reg.sat_reg;
                assign sum_next = {chunk_sum[CW-1:0], g_stage[gi-1].g_reg.sum_reg};
            end

            assign chunk_sum = {1'b0, rem_a[CW-1:0]} + {1'b0, rem_bp[CW-1:0]} + (CW+1)'(carry_in);
            assign zero_next = zero_in & (chunk_sum[CW-1:0] == '0);

            if (gi < STAGES - 1) begin : g_reg
                logic                valid_reg;
                logic [REM_W-CW-1:0] a_reg;
                logic [REM_W-CW-1:0] bp_reg;
                logic [DONE_W-1:0]   sum_reg;
                logic                carry_reg;
                logic                zero_reg;
                logic                sat_reg;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                    end else if (adv) begin
                        valid_reg <= valid_in;
                    end
                end

                always_ff @(posedge clk) begin
                    if (adv) begin
                        a_reg     <= rem_a[REM_W-1:CW];
                        bp_reg    <= rem_bp[REM_W-1:CW];
                        sum_reg   <= sum_next;
                        carry_reg <= chunk_sum[CW];
                        zero_reg  <= zero_next;
                        sat_reg   <= sat_in;
                    end
                end
            end else begin : g_tail
                logic a_msb;
                logic bp_msb;
                logic ovf;

                assign a_msb  = rem_a[CW-1];
                assign bp_msb = rem_bp[CW-1];
                assign ovf    = (a_msb ^ sum_next[WIDTH-1]) & ~(a_msb ^ bp_msb);

                assign fin_valid  = valid_in;
                assign fin_c      = chunk_sum[CW];
                assign fin_v      = ovf;
                // A saturated value is never zero, so z only survives on the wrap path.
                assign fin_result = (sat_in & ovf) ? (a_msb ? SAT_MIN : SAT_MAX) : sum_next;
                assign fin_z      = zero_next & ~(sat_in & ovf);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= fin_valid;
            result_reg    <= fin_result;
            c_reg         <= fin_c;
            v_reg         <= fin_v;
            n_reg         <= fin_result[WIDTH-1];
            z_reg         <= fin_z;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign c_flag    = c_reg;
    assign v_flag    = v_reg;
    assign n_flag    = n_reg;
    assign z_flag    = z_reg;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub: 64-bit/4-stage vector table, stall stream, mid-flight reset, 32-bit/1-stage latency.
module tb_pipe_addsub;
    localparam int W = 64;
    localparam int S = 4;
    localparam int NV = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_flag;
    logic         v_flag;
    logic         n_flag;
    logic         z_flag;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [1:0]   s_op;
    logic [31:0]  s_a;
    logic [31:0]  s_b;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [31:0]  s_result;
    logic         s_c;
    logic         s_v;
    logic         s_n;
    logic         s_z;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_flag(c_flag), .v_flag(v_flag), .n_flag(n_flag), .z_flag(z_flag)
    );

    pipe_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .c_flag(s_c), .v_flag(s_v), .n_flag(s_n), .z_flag(s_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } vec_t;

    vec_t vecs [NV];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        in_valid  = 1'b1;
        op        = vecs[i].op;
        a         = vecs[i].a;
        b         = vecs[i].b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("v%0d_latency", i), 64'(lat), 64'(S));
        check($sformatf("v%0d_result", i), result, vecs[i].res);
        check($sformatf("v%0d_nzcv", i), {n_flag, z_flag, c_flag, v_flag}, vecs[i].nzcv);
        $display("vec %0d op=%b a=%h b=%h result=%h nzcv=%b lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b,
                 result, {n_flag, z_flag, c_flag, v_flag}, lat);
        @(posedge clk); #1;
        check($sformatf("v%0d_no_dup", i), out_valid, 1'b0);
    endtask

    initial begin
        int issued;
        int got;
        logic held;
        logic [W-1:0] held_res;
        logic saw_block;

        vecs[0]  = '{2'b01, 64'h5, 64'h5, 64'h0, 4'b0110};
        vecs[1]  = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b1001};
`ifdef PIPE_ADDSUB_SAT_EN
        vecs[2]  = '{2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001};
`else
        vecs[2]  = '{2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 4'b1001};
`endif
        vecs[3]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b0110};
        vecs[4]  = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b1001};
        vecs[5]  = '{2'b00, 64'h1, 64'h2, 64'h3, 4'b0000};
        vecs[6]  = '{2'b01, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
        vecs[7]  = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b0111};
        vecs[8]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
`ifdef PIPE_ADDSUB_SAT_EN
        vecs[9]  = '{2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0000, 4'b1011};
`else
        vecs[9]  = '{2'b11, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
`endif
        vecs[10] = '{2'b00, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 4'b0000};
        vecs[11] = '{2'b01, 64'h0, 64'h0, 64'h0, 4'b0110};
        vecs[12] = '{2'b10, 64'h1, 64'h1, 64'h2, 4'b0000};
        vecs[13] = '{2'b00, 64'h0001_0000_0000_0000, 64'h0, 64'h0001_0000_0000_0000, 4'b0000};
        vecs[14] = '{2'b01, 64'h0000_0000_0001_0000, 64'h1, 64'h0000_0000_0000_FFFF, 4'b0010};

        // Reset held with live stimulus: outputs must stay cleared.
        reset       = 1'b1;
        in_valid    = 1'b1;
        op          = 2'b01;
        a           = 64'h5;
        b           = 64'h5;
        out_ready   = 1'b1;
        s_in_valid  = 1'b0;
        s_op        = 2'b00;
        s_a         = 32'h0;
        s_b         = 32'h0;
        s_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("reset_out_valid", out_valid, 1'b0);
            check("reset_result", result, 64'h0);
            check("reset_flags", {n_flag, z_flag, c_flag, v_flag}, 4'b0000);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // Back-to-back stream of 8 ops, consumer stalls during cycles 3..6.
        issued    = 0;
        got       = 0;
        held      = 1'b0;
        held_res  = '0;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (issued < 8);
            if (issued < 8) begin
                op = vecs[issued].op;
                a  = vecs[issued].a;
                b  = vecs[issued].b;
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                check("stream_in_ready_stall", in_ready, 1'b0);
                saw_block = 1'b1;
            end
            if (out_ready) begin
                check("stream_in_ready_flow", in_ready, 1'b1);
            end
            if (held) begin
                check("stream_head_stable", result, held_res);
            end
            held     = out_valid && !out_ready;
            held_res = result;
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d_result", got), result, vecs[got].res);
                check($sformatf("stream%0d_nzcv", got), {n_flag, z_flag, c_flag, v_flag}, vecs[got].nzcv);
                $display("stream out %0d result=%h nzcv=%b cyc=%0d", got, result,
                         {n_flag, z_flag, c_flag, v_flag}, cyc);
                got++;
            end
            if (in_valid && in_ready) begin
                issued++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd8);
        check("stream_saw_block", saw_block, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("stream_drained", out_valid, 1'b0);
        end

        // Reset with three ops in flight: nothing from them may ever appear.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            op       = vecs[5 + k].op;
            a        = vecs[5 + k].a;
            b        = vecs[5 + k].b;
            @(posedge clk); #1;
            $display("flush issue %0d a=%h b=%h", k, vecs[5 + k].a, vecs[5 + k].b);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_result", result, 64'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("flush_no_stale", out_valid, 1'b0);
        end

        // 32-bit single-stage instance: latency exactly one cycle.
        s_in_valid = 1'b1;
        s_op       = 2'b01;
        s_a        = 32'd3;
        s_b        = 32'd5;
        #1;
        check("s1_pre_edge_valid", s_out_valid, 1'b0);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("s1_valid", s_out_valid, 1'b1);
        check("s1_result", s_result, 32'hFFFF_FFFE);
        check("s1_nzcv", {s_n, s_z, s_c, s_v}, 4'b1000);
        $display("s1 sub a=3 b=5 result=%h nzcv=%b", s_result, {s_n, s_z, s_c, s_v});
        s_in_valid = 1'b1;
        s_op       = 2'b00;
        s_a        = 32'hFFFF_FFFF;
        s_b        = 32'h1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("s1_add_result", s_result, 32'h0);
        check("s1_add_nzcv", {s_n, s_z, s_c, s_v}, 4'b0110);
        $display("s1 add a=ffffffff b=1 result=%h nzcv=%b", s_result, {s_n, s_z, s_c, s_v});
        @(posedge clk); #1;
        check("s1_drained", s_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
